// File: rtl/control_unit.sv
// Main decoder for the 5-stage MIPS pipeline.
// Turns the ID-stage opcode into WB/MEM/EX control bundles and registers
// them into the ID/EX stage. Anything that is not R-type, LW, SW or BEQ
// (including X/Z opcodes in simulation) decodes to a bubble: all zeros.
module control_unit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] OpCode,
   output logic [1:0] WB,
   output logic [2:0] MEM,
   output logic [3:0] EX
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   logic       reg_write;
   logic       mem_to_reg;
   logic       branch;
   logic       mem_read;
   logic       mem_write;
   logic       reg_dst;
   logic [1:0] alu_op;
   logic       alu_src;

   // Opcode decode; every field defaults to 0 so don't-cares and unknown
   // opcodes never propagate X into the pipeline.
   always_comb begin
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      branch     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_dst    = 1'b0;
      alu_op     = ALUOP_ADD;
      alu_src    = 1'b0;
      case (OpCode)
         OP_RTYPE: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            alu_op    = ALUOP_FUNCT;
         end
         OP_LW: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            mem_read   = 1'b1;
            alu_src    = 1'b1;
         end
         OP_SW: begin
            mem_write = 1'b1;
            alu_src   = 1'b1;
         end
         OP_BEQ: begin
            branch = 1'b1;
            alu_op = ALUOP_SUB;
         end
         default: begin
         end
      endcase
   end

   // ID/EX control register; async clear inserts a bubble immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         WB  <= 2'b00;
         MEM <= 3'b000;
         EX  <= 4'b0000;
      end else begin
         WB  <= {reg_write, mem_to_reg};
         MEM <= {branch, mem_read, mem_write};
         EX  <= {reg_dst, alu_op, alu_src};
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed pipeline/reset scenarios followed by a
// randomized opcode stream, all compared against a table-driven decoder.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] OpCode = 6'b100011;
   logic [1:0] WB;
   logic [2:0] MEM;
   logic [3:0] EX;

   int checks = 0;
   int errors = 0;

   logic [5:0] known_ops  [4];
   logic [8:0] known_ctrl [4];

   always #5 clk = ~clk;

   control_unit dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .OpCode (OpCode),
      .WB     (WB),
      .MEM    (MEM),
      .EX     (EX)
   );

   // Reference decode: look the opcode up in the instruction table, bubble otherwise.
   function automatic logic [8:0] ref_decode(input logic [5:0] op);
      logic [8:0] r;
      r = 9'b0;
      for (int i = 0; i < 4; i++)
         if (known_ops[i] === op) r = known_ctrl[i];
      return r;
   endfunction

   function automatic logic [8:0] outs();
      return {WB, MEM, EX};
   endfunction

   task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %b_%b_%b expected %b_%b_%b", tag,
                  obs[8:7], obs[6:4], obs[3:0], exp[8:7], exp[6:4], exp[3:0]);
      end
   endtask

   // Present an opcode between edges and check it one edge later.
   task automatic apply(input string tag, input logic [5:0] op);
      @(negedge clk);
      OpCode = op;
      @(posedge clk);
      #1;
      check(tag, outs(), ref_decode(op));
   endtask

   initial begin
      logic [5:0] op;
      known_ops[0] = 6'b000000; known_ctrl[0] = 9'b10_000_1100;
      known_ops[1] = 6'b100011; known_ctrl[1] = 9'b11_010_0001;
      known_ops[2] = 6'b101011; known_ctrl[2] = 9'b00_001_0001;
      known_ops[3] = 6'b000100; known_ctrl[3] = 9'b00_100_0010;

      // Held in reset with LW presented and clock running.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_hold", outs(), 9'b0);
      end

      // Release; first edge loads LW.
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_release_pre_edge", outs(), 9'b0);
      @(posedge clk);
      #1;
      check("lw_first", outs(), 9'b11_010_0001);

      apply("sw", 6'b101011);
      apply("beq", 6'b000100);
      apply("rtype", 6'b000000);
      apply("illegal_3f", 6'b111111);
      apply("lw_again", 6'b100011);

      // Opcode change between edges must not reach the outputs early.
      @(negedge clk);
      OpCode = 6'b000100;
      #2;
      check("hold_between_edges", outs(), 9'b11_010_0001);
      OpCode = 6'b000000;
      #1;
      check("hold_between_edges2", outs(), 9'b11_010_0001);
      @(posedge clk);
      #1;
      check("late_change_taken", outs(), 9'b10_000_1100);

      // Asynchronous reset pulse between edges with R-type held.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_clear", outs(), 9'b0);
      rst_n = 1'b1;
      #1;
      check("async_clear_held", outs(), 9'b0);
      @(posedge clk);
      #1;
      check("rtype_restored", outs(), 9'b10_000_1100);

      // Randomized opcode stream with occasional asynchronous reset pulses.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 1) == 0)
            op = known_ops[$urandom_range(0, 3)];
         else
            op = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 19) == 0) begin
            @(negedge clk);
            OpCode = op;
            #2;
            rst_n = 1'b0;
            #1;
            check("rand_async_clear", outs(), 9'b0);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            check("rand_after_reset", outs(), ref_decode(op));
         end else begin
            apply("rand", op);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
